// File: rtl/game_pkg.sv
// Shared definitions for the game flow controller: state encoding,
// level ceiling and the level thresholds that select obstacle speed.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_LEVEL_UP  = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam logic [6:0] MAX_LEVEL = 7'd99;

    // First level of each faster speed tier.
    localparam logic [6:0] SPEED_T1 = 7'd4;
    localparam logic [6:0] SPEED_T2 = 7'd7;
    localparam logic [6:0] SPEED_T3 = 7'd10;

    // Maps a level number onto one of four obstacle speed tiers.
    function automatic logic [1:0] speed_tier(input logic [6:0] level);
        if (level >= SPEED_T3)      return 2'd3;
        else if (level >= SPEED_T2) return 2'd2;
        else if (level >= SPEED_T1) return 2'd1;
        else                        return 2'd0;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector. The pulse is registered, so it is high for the one
// clock that follows the edge at which the input was first seen high.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev_reg;
    logic rise_reg;

    // Remember the previous sample and flag a low-to-high transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            prev_reg <= din;
            rise_reg <= din & ~prev_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: start/play/level-up/game-over sequencing, lives
// bookkeeping, level counter control pulses and display blanking.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int HOLD_CYCLES  = 25_000_000,
    parameter int BLINK_CYCLES = 6_250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_frog_at_top,
    input  logic       i_collision,
    input  logic [6:0] i_level,
    output logic       o_level_inc,
    output logic       o_level_reset,
    output logic       o_frog_reset,
    output logic       o_freeze,
    output logic       o_blank,
    output logic [1:0] o_lives,
    output logic [1:0] o_state,
    output logic [1:0] o_speed_sel
);

    // A one-cycle parameter would give a zero-width counter; keep one bit.
    localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);

    // Bit 0 start, bit 1 frog at top, bit 2 collision.
    logic [2:0] raw_in;
    logic [2:0] rise_vec;
    logic       start_rise;
    logic       top_rise;
    logic       col_rise;

    assign raw_in     = {i_collision, i_frog_at_top, i_start};
    assign start_rise = rise_vec[0];
    assign top_rise   = rise_vec[1];
    assign col_rise   = rise_vec[2];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge
            edge_rise u_edge (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (raw_in[gi]),
                .rise  (rise_vec[gi])
            );
        end
    endgenerate

    state_t               state_reg,       state_next;
    logic [1:0]           lives_reg,       lives_next;
    logic                 level_inc_reg,   level_inc_next;
    logic                 level_reset_reg, level_reset_next;
    logic                 frog_reset_reg,  frog_reset_next;
    logic                 freeze_reg,      freeze_next;
    logic                 blank_reg,       blank_next;
    logic [1:0]           speed_reg;
    logic [HOLD_W-1:0]    hold_reg,        hold_next;
    logic [BLINK_W-1:0]   blink_reg,       blink_next;

    // State and every output are registered; reset aborts any game at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            lives_reg       <= 2'd0;
            level_inc_reg   <= 1'b0;
            level_reset_reg <= 1'b0;
            frog_reset_reg  <= 1'b0;
            freeze_reg      <= 1'b1;
            blank_reg       <= 1'b0;
            speed_reg       <= 2'd0;
            hold_reg        <= '0;
            blink_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            lives_reg       <= lives_next;
            level_inc_reg   <= level_inc_next;
            level_reset_reg <= level_reset_next;
            frog_reset_reg  <= frog_reset_next;
            freeze_reg      <= freeze_next;
            blank_reg       <= blank_next;
            speed_reg       <= speed_tier(i_level);
            hold_reg        <= hold_next;
            blink_reg       <= blink_next;
        end
    end

    // Next-state, lives, counters and pulses from the detected input rises.
    always_comb begin
        state_next       = state_reg;
        lives_next       = lives_reg;
        level_inc_next   = 1'b0;
        level_reset_next = 1'b0;
        frog_reset_next  = 1'b0;
        freeze_next      = freeze_reg;
        blank_next       = blank_reg;
        hold_next        = hold_reg;
        blink_next       = blink_reg;

        // Display blinks while frozen in LEVEL_UP or GAME_OVER.
        if (state_reg == ST_LEVEL_UP || state_reg == ST_GAME_OVER) begin
            if (blink_reg == BLINK_LAST) begin
                blink_next = '0;
                blank_next = ~blank_reg;
            end else begin
                blink_next = blink_reg + BLINK_W'(1);
            end
        end

        case (state_reg)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_rise) begin
                    state_next       = ST_PLAY;
                    lives_next       = LIVES_LOAD;
                    level_reset_next = 1'b1;
                    frog_reset_next  = 1'b1;
                    freeze_next      = 1'b0;
                    blank_next       = 1'b0;
                end
            end
            ST_PLAY: begin
                // A collision in the same cycle as reaching the top wins.
                if (col_rise) begin
                    if (lives_reg > 2'd1) begin
                        lives_next      = lives_reg - 2'd1;
                        frog_reset_next = 1'b1;
                    end else begin
                        lives_next  = 2'd0;
                        state_next  = ST_GAME_OVER;
                        freeze_next = 1'b1;
                        blank_next  = 1'b1;
                        blink_next  = '0;
                    end
                end else if (top_rise) begin
                    state_next      = ST_LEVEL_UP;
                    frog_reset_next = 1'b1;
                    level_inc_next  = (i_level < MAX_LEVEL);
                    hold_next       = HOLD_LOAD;
                    freeze_next     = 1'b1;
                    blank_next      = 1'b1;
                    blink_next      = '0;
                end
            end
            ST_LEVEL_UP: begin
                if (hold_reg == '0) begin
                    state_next  = ST_PLAY;
                    freeze_next = 1'b0;
                    blank_next  = 1'b0;
                end else begin
                    hold_next = hold_reg - HOLD_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_state       = state_reg;
    assign o_lives       = lives_reg;
    assign o_level_inc   = level_inc_reg;
    assign o_level_reset = level_reset_reg;
    assign o_frog_reset  = frog_reset_reg;
    assign o_freeze      = freeze_reg;
    assign o_blank       = blank_reg;
    assign o_speed_sel   = speed_reg;

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded at game start, legal range 1..3.
REQ-002 Parameter HOLD_CYCLES, default 25_000_000: LEVEL_UP freeze duration in clocks (1 s at 25 MHz).
REQ-003 Parameter BLINK_CYCLES, default 6_250_000: half-period of the o_blank toggle.
REQ-004 Port clk  in  1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 Port i_start  in  1: debounced start button, active-high, synchronous to clk.
REQ-007 Port i_frog_at_top  in  1: frog reached top row; may stay high for many cycles.
REQ-008 Port i_collision  in  1: frog hit an obstacle; may stay high for many cycles.
REQ-009 Port i_level  in  7: current level from the level counter, 1..99.
REQ-010 Port o_level_inc  out  1: one-cycle pulse that advances the level counter.
REQ-011 Port o_level_reset  out  1: one-cycle pulse that returns the level counter to 1.
REQ-012 Port o_frog_reset  out  1: one-cycle pulse that returns the frog to bottom centre.
REQ-013 Port o_freeze  out  1: high means game objects halt.
REQ-014 Port o_blank  out  1: high means the 7-segment displays are blanked.
REQ-015 Port o_lives  out  2: remaining lives.
REQ-016 Port o_state  out  2: IDLE=0, PLAY=1, LEVEL_UP=2, GAME_OVER=3.
REQ-017 Port o_speed_sel  out  2: obstacle speed tier.

Function
REQ-018 Edge detection: rise on i_start, i_frog_at_top and i_collision is detected when the current sample is 1 and the previous sample was 0; previous samples are registered.
REQ-019 Latency: every output is registered; a pulse or state change appears exactly one clock after the edge in which the rise is sampled.
REQ-020 IDLE: o_freeze=1, o_blank=0; a start rise moves to PLAY, loads o_lives=LIVES_INIT, and pulses o_level_reset and o_frog_reset together.
REQ-021 PLAY, collision rise with o_lives>1: o_lives decrements by 1, o_frog_reset pulses, and the block stays in PLAY.
REQ-022 PLAY, collision rise with o_lives==1: o_lives becomes 0 and the block moves to GAME_OVER; there is no frog reset.
REQ-023 PLAY, frog_at_top rise: the block moves to LEVEL_UP, pulses o_frog_reset, pulses o_level_inc only if i_level<99, and loads the hold timer with HOLD_CYCLES-1.
REQ-024 PLAY, collision and frog_at_top rise in the same cycle: collision wins; the frog_at_top rise is discarded.
REQ-025 LEVEL_UP: o_freeze=1; o_blank starts at 1 and toggles every BLINK_CYCLES clocks; when the timer reaches 0, the block moves to PLAY with o_blank=0 and o_freeze=0.
REQ-026 LEVEL_UP: all input edges are ignored, including start.
REQ-027 GAME_OVER: o_freeze=1; o_blank toggles as in LEVEL_UP; a start rise behaves exactly as in IDLE (REQ-020).
REQ-028 PLAY: o_freeze=0, o_blank=0; a start rise is ignored.
REQ-029 o_speed_sel is registered from i_level: 1..3→0, 4..6→1, 7..9→2, ≥10→3; i_level=0 maps to 0.
REQ-030 Counters: the hold and blink counters are sized by $clog2 of their parameters; the blink counter is cleared on every entry to LEVEL_UP or GAME_OVER.
REQ-031 No more than one o_frog_reset pulse is generated per detected edge.

Reset
REQ-032 While rst_n=0: state=IDLE, o_lives=0, o_freeze=1, o_blank=0, all pulses=0, o_speed_sel=0, edge registers=0, counters=0.
REQ-033 Reset asserted mid-LEVEL_UP or mid-GAME_OVER aborts immediately; no pulse is emitted on release.
REQ-034 The first start rise after reset release starts a game from level 1.

Structure
REQ-035 Shared package game_pkg holds the state enum/encoding, MAX_LEVEL=99, and the speed-tier thresholds.
REQ-036 One sub-module, edge_rise, is instantiated three times (start, frog_at_top, collision).

Verification
REQ-037 Reset, then start rise → one clock later: state=1, o_lives=3, o_level_reset=1 and o_frog_reset=1 for exactly 1 cycle.
REQ-038 PLAY, frog_at_top held high for 10 cycles → one o_level_inc pulse and state=2; with HOLD_CYCLES=8, state=1 after 8 clocks.
REQ-039 PLAY with lives=3, three separate collision rises → lives go 2, 1, 0; state=3 after the third; frog reset pulses only twice.
REQ-040 PLAY, collision and frog_at_top rise in the same cycle with lives=2 → lives=1, state stays 1, no o_level_inc.
REQ-041 i_level=99, frog_at_top rise → state=2, o_frog_reset pulse, o_level_inc stays 0; i_level sweep 1..12 yields o_speed_sel per REQ-029.
REQ-042 rst_n dropped during LEVEL_UP with BLINK_CYCLES=2 → all outputs equal REQ-032 values within the same cycle, asynchronously.
